// File: rtl/imem_boot_loader.sv
// imem_boot_loader: UART (8N1) boot loader that streams a word-count header plus
// a little-endian 32-bit image into instruction memory from word address 0,
// holding the core in reset until the whole image has been received.
module imem_boot_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DEPTH        = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]      DEPTH_W  = 17'(DEPTH);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        LD_HDR0,
        LD_HDR1,
        LD_DATA,
        LD_DONE
    } ld_state_t;

    // rx synchronizer
    logic r_rx_meta;
    logic r_rx_s;

    // UART receiver
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_byte_valid;
    logic [7:0]       r_byte;
    logic             r_frame_err;

    // image loader
    ld_state_t   r_ld_state;
    logic [15:0] r_count;
    logic [15:0] r_word_cnt;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_word;
    logic        r_fin;

    logic        w_in_range;
    logic [15:0] w_word_cnt_nx;

    assign w_in_range    = ({1'b0, r_word_cnt} < DEPTH_W);
    assign w_word_cnt_nx = r_word_cnt + 16'd1;

    // Two-flop synchronizer; both flops reset to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // 8N1 receiver: half-bit start check, then mid-bit sampling of data and stop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s) begin
                        r_rx_state <= RX_START;
                        r_bit_cnt  <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (r_bit_cnt == '0) begin
                        if (!r_rx_s) begin
                            r_rx_state <= RX_DATA;
                            r_bit_cnt  <= FULL_BIT;
                            r_bit_idx  <= '0;
                        end else begin
                            // start bit vanished before mid-bit: line glitch
                            r_rx_state <= RX_IDLE;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_bit_cnt == '0) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_cnt <= FULL_BIT;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_bit_cnt == '0) begin
                        if (r_rx_s) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Loader: header, word assembly, memory writes and completion/error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_state   <= LD_HDR0;
            r_count      <= '0;
            r_word_cnt   <= '0;
            r_byte_idx   <= '0;
            r_word       <= '0;
            r_fin        <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            core_rst_n   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
        end else begin
            imem_we <= 1'b0;
            // once loaded, line noise no longer matters
            if (r_frame_err && (r_ld_state != LD_DONE)) begin
                err <= 1'b1;
            end
            case (r_ld_state)
                LD_HDR0: begin
                    if (r_byte_valid) begin
                        r_count[7:0] <= r_byte;
                        r_ld_state   <= LD_HDR1;
                    end
                end
                LD_HDR1: begin
                    if (r_byte_valid) begin
                        r_count[15:8] <= r_byte;
                        if ({r_byte, r_count[7:0]} == 16'd0) begin
                            r_ld_state <= LD_DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            r_ld_state <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (r_fin) begin
                        // one cycle after the final word's write slot
                        r_ld_state <= LD_DONE;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end else if (r_byte_valid) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        case (r_byte_idx)
                            2'd0: r_word[7:0]   <= r_byte;
                            2'd1: r_word[15:8]  <= r_byte;
                            2'd2: r_word[23:16] <= r_byte;
                            default: begin
                                if (w_in_range) begin
                                    imem_we      <= 1'b1;
                                    imem_addr    <= ADDR_W'(r_word_cnt);
                                    imem_wdata   <= {r_byte, r_word};
                                    words_loaded <= words_loaded + 16'd1;
                                end else begin
                                    // word beyond memory: consumed but dropped
                                    err <= 1'b1;
                                end
                                r_word_cnt <= w_word_cnt_nx;
                                if (w_word_cnt_nx == r_count) begin
                                    r_fin <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                LD_DONE: begin
                    r_ld_state <= LD_DONE;
                end
                default: r_ld_state <= LD_HDR0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances share clk/rst/rx, one with room for
// 16 words and one with only 2, so every stream also exercises overflow.
module tb_imem_boot_loader;

    localparam int unsigned CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;

    logic        a_we, o_we;
    logic [7:0]  a_addr, o_addr;
    logic [31:0] a_wdata, o_wdata;
    logic        a_crn, o_crn, a_done, o_done, a_err, o_err;
    logic [15:0] a_wl, o_wl;

    imem_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .DEPTH(16)) u_dut (
        .clk(clk), .rst(rst), .rx(rx),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .core_rst_n(a_crn), .done(a_done), .err(a_err), .words_loaded(a_wl)
    );

    imem_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(8), .DEPTH(2)) u_ovf (
        .clk(clk), .rst(rst), .rx(rx),
        .imem_we(o_we), .imem_addr(o_addr), .imem_wdata(o_wdata),
        .core_rst_n(o_crn), .done(o_done), .err(o_err), .words_loaded(o_wl)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // observed writes per instance
    logic [31:0] got_a[$];
    logic [31:0] got_o[$];
    int          last_we_a = -1;
    int          rise_a    = -1;
    logic        a_done_q  = 1'b0;

    // stimulus stream for the model and random tests
    logic [7:0]  bs[$];
    bit          bad[$];
    logic [31:0] mq[$];

    typedef struct packed {
        logic [4:0]         nb;
        logic [0:15][7:0]   b;
        logic [4:0]         bad;
        logic [1:0]         a_nw;
        logic [0:2][31:0]   a_w;
        logic               a_err;
        logic               a_done;
        logic [1:0]         o_nw;
        logic               o_err;
        logic               o_done;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Every write strobe must target the next sequential address and bump words_loaded
    always @(negedge clk) begin
        if (!rst) begin
            if (a_we) begin
                n_chk++;
                if (a_addr !== 8'(got_a.size()) || a_wl !== 16'(got_a.size() + 1)) begin
                    n_err++;
                    $display("FAIL mon_a addr=%0d wl=%0d exp_idx=%0d", a_addr, a_wl, got_a.size());
                end
                got_a.push_back(a_wdata);
                last_we_a = cyc;
            end
            if (o_we) begin
                n_chk++;
                if (o_addr !== 8'(got_o.size()) || o_wl !== 16'(got_o.size() + 1)) begin
                    n_err++;
                    $display("FAIL mon_o addr=%0d wl=%0d exp_idx=%0d", o_addr, o_wl, got_o.size());
                end
                got_o.push_back(o_wdata);
            end
            if (a_done && !a_done_q) rise_a = cyc;
            a_done_q = a_done;
        end
    end

    task automatic rx_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        rx_bit(!bad_stop);
        if (bad_stop) begin
            rx_bit(1'b1);
            rx_bit(1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        chk("rst_a", 64'({a_we, a_addr, a_wdata, a_crn, a_done, a_err, a_wl}), 64'd0);
        chk("rst_o", 64'({o_we, o_addr, o_wdata, o_crn, o_done, o_err, o_wl}), 64'd0);
        got_a.delete();
        got_o.delete();
        last_we_a = -1;
        rise_a    = -1;
        a_done_q  = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic settle();
        repeat (3 * CPB) @(negedge clk);
    endtask

    task automatic check_inst(input string tag, input logic [31:0] got[$], input logic [31:0] exp[$],
                              input logic err_g, input logic done_g, input logic crn_g,
                              input logic [15:0] wl_g, input bit err_e, input bit done_e);
        chk({tag, "_nwr"}, 64'(got.size()), 64'(exp.size()));
        for (int k = 0; k < got.size() && k < exp.size(); k++)
            chk({tag, "_word"}, 64'(got[k]), 64'(exp[k]));
        chk({tag, "_err"}, 64'(err_g), 64'(err_e));
        chk({tag, "_done"}, 64'(done_g), 64'(done_e));
        chk({tag, "_crn"}, 64'(crn_g), 64'(done_e));
        chk({tag, "_wl"}, 64'(wl_g), 64'(exp.size()));
    endtask

    // Reference: drop bad bytes (flagging err while not yet complete), then
    // take the header count and cut the rest into little-endian words.
    task automatic model(input int depth, output bit e_err, output bit e_done);
        logic [7:0]  v[$];
        int          need;
        int          cnt;
        int          nw;
        mq.delete();
        e_err  = 1'b0;
        e_done = 1'b0;
        for (int i = 0; i < bs.size() && !e_done; i++) begin
            if (bad[i]) e_err = 1'b1;
            else v.push_back(bs[i]);
            if (v.size() >= 2) begin
                need = 2 + 4 * int'({v[1], v[0]});
                if (v.size() >= need) e_done = 1'b1;
            end
        end
        if (v.size() >= 2) begin
            cnt = int'({v[1], v[0]});
            nw  = (v.size() - 2) / 4;
            if (nw > cnt) nw = cnt;
            for (int k = 0; k < nw; k++) begin
                if (k < depth) mq.push_back({v[2+4*k+3], v[2+4*k+2], v[2+4*k+1], v[2+4*k]});
                else e_err = 1'b1;
            end
        end
    endtask

    initial begin
        logic [31:0] ea[$];
        logic [31:0] eo[$];
        bit          ae, ad, oe, od;
        int          cnt;
        int          pos;

        tv[0] = '{nb: 5'd10, b: {80'h02001305000093051000, 48'h0}, bad: 5'd31,
                  a_nw: 2'd2, a_w: {32'h00000513, 32'h00100593, 32'h0}, a_err: 1'b0, a_done: 1'b1,
                  o_nw: 2'd2, o_err: 1'b0, o_done: 1'b1};
        tv[1] = '{nb: 5'd2, b: {16'h0000, 112'h0}, bad: 5'd31,
                  a_nw: 2'd0, a_w: {96'h0}, a_err: 1'b0, a_done: 1'b1,
                  o_nw: 2'd0, o_err: 1'b0, o_done: 1'b1};
        tv[2] = '{nb: 5'd7, b: {56'h0100AA11223344, 72'h0}, bad: 5'd2,
                  a_nw: 2'd1, a_w: {32'h44332211, 64'h0}, a_err: 1'b1, a_done: 1'b1,
                  o_nw: 2'd1, o_err: 1'b1, o_done: 1'b1};
        tv[3] = '{nb: 5'd14, b: {112'h0300_0102030405060708090A0B0C, 16'h0}, bad: 5'd31,
                  a_nw: 2'd3, a_w: {32'h04030201, 32'h08070605, 32'h0C0B0A09}, a_err: 1'b0, a_done: 1'b1,
                  o_nw: 2'd2, o_err: 1'b1, o_done: 1'b1};
        tv[4] = '{nb: 5'd6, b: {48'h0200EFBEADDE, 80'h0}, bad: 5'd31,
                  a_nw: 2'd1, a_w: {32'hDEADBEEF, 64'h0}, a_err: 1'b0, a_done: 1'b0,
                  o_nw: 2'd1, o_err: 1'b0, o_done: 1'b0};
        tv[5] = '{nb: 5'd11, b: {88'h0100785634_12AA55667788, 40'h0}, bad: 5'd6,
                  a_nw: 2'd1, a_w: {32'h12345678, 64'h0}, a_err: 1'b0, a_done: 1'b1,
                  o_nw: 2'd1, o_err: 1'b0, o_done: 1'b1};

        repeat (3) @(negedge clk);

        // directed table
        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int i = 0; i < int'(tv[t].nb); i++)
                send_byte(tv[t].b[i], i == int'(tv[t].bad));
            settle();
            ea.delete();
            eo.delete();
            for (int k = 0; k < int'(tv[t].a_nw); k++) ea.push_back(tv[t].a_w[k]);
            for (int k = 0; k < int'(tv[t].o_nw); k++) eo.push_back(tv[t].a_w[k]);
            check_inst($sformatf("vec%0d_a", t), got_a, ea, a_err, a_done, a_crn, a_wl, tv[t].a_err, tv[t].a_done);
            check_inst($sformatf("vec%0d_o", t), got_o, eo, o_err, o_done, o_crn, o_wl, tv[t].o_err, tv[t].o_done);
            if (tv[t].a_done && tv[t].a_nw != 2'd0)
                chk($sformatf("vec%0d_done_lat", t), 64'(rise_a), 64'(last_we_a + 1));
        end

        // start glitch shorter than half a bit between header and data
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_err", 64'(a_err), 64'd0);
        chk("glitch_nwr", 64'(got_a.size()), 64'd0);
        chk("glitch_done", 64'(a_done), 64'd0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        settle();
        ea = '{32'h44332211};
        check_inst("glitch_a", got_a, ea, a_err, a_done, a_crn, a_wl, 1'b0, 1'b1);

        // reset mid-load with a byte in flight, then full resend
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(tv[0].b[i], 1'b0);
        rx_bit(1'b0);
        rx_bit(1'b1);
        rx_bit(1'b0);
        chk("midload_nwr", 64'(got_a.size()), 64'd1);
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(tv[0].b[i], 1'b0);
        settle();
        ea = '{32'h00000513, 32'h00100593};
        check_inst("resend_a", got_a, ea, a_err, a_done, a_crn, a_wl, 1'b0, 1'b1);
        chk("resend_done_lat", 64'(rise_a), 64'(last_we_a + 1));

        // random images against the reference model
        for (int it = 0; it < 8; it++) begin
            bs.delete();
            bad.delete();
            cnt = $urandom_range(0, 4);
            bs.push_back(8'(cnt));
            bs.push_back(8'h00);
            for (int k = 0; k < 4 * cnt; k++) bs.push_back(8'($urandom));
            for (int k = 0; k < bs.size(); k++) bad.push_back(1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) if (bs.size() > 0) begin
                    void'(bs.pop_back());
                    void'(bad.pop_back());
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                pos = $urandom_range(0, bs.size());
                bs.insert(pos, 8'($urandom));
                bad.insert(pos, 1'b1);
            end
            if ($urandom_range(0, 1) == 1) begin
                bs.push_back(8'($urandom));
                bad.push_back(1'b0);
            end
            model(16, ae, ad);
            ea = mq;
            model(2, oe, od);
            eo = mq;
            do_reset();
            for (int i = 0; i < bs.size(); i++) send_byte(bs[i], bad[i]);
            settle();
            check_inst($sformatf("rnd%0d_a", it), got_a, ea, a_err, a_done, a_crn, a_wl, ae, ad);
            check_inst($sformatf("rnd%0d_o", it), got_o, eo, o_err, o_done, o_crn, o_wl, oe, od);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- UART boot loader that writes a program image into instruction memory; the core only reads that memory.
- Receives 8N1 serial bytes, reads a 16-bit word-count header, then assembles little-endian 32-bit words and writes them to sequential word addresses from 0.
- Holds the core in reset until the load completes.
- Sits beside the core top level: drives the instruction-memory write port and the core's active-low reset.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 4.
- ADDR_W, 8, instruction-memory word-address width.
- DEPTH, 256, number of writable words; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  UART serial input; idles high; asynchronous to clk.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the current write.
- imem_wdata  out  32  word being written.
- core_rst_n  out  1  active-low reset to the core; 0 until load is done.
- done  out  1  load complete; sticky until rst.
- err  out  1  sticky error: framing error or word overflow.
- words_loaded  out  16  count of words actually written.

Behaviour:
- Reset values: imem_we=0, imem_addr=0, imem_wdata=0, core_rst_n=0, done=0, err=0, words_loaded=0. All internal state cleared; both synchronizer flops set to 1.
- rst asserted mid-load: everything above is cleared on the next clk edge and the partial image is abandoned. Any byte in flight is discarded.
- rx path: 2-flop synchronizer feeds rx_s. All sampling uses rx_s.
- RX FSM, IDLE:
  - rx_s==0 → START; bit counter loaded for CLKS_PER_BIT/2 cycles.
- RX FSM, START:
  - At mid-bit, rx_s==0 → DATA.
  - At mid-bit, rx_s==1 → IDLE (glitch rejected; no byte, no err).
- RX FSM, DATA:
  - Samples every CLKS_PER_BIT cycles, LSB first, 8 bits, then → STOP.
- RX FSM, STOP:
  - Samples after CLKS_PER_BIT cycles.
  - rx_s==1: internal byte_valid pulses for one cycle with the byte.
  - rx_s==0: framing error; err←1, byte discarded.
  - Either case → IDLE.
- Loader FSM, states HDR0, HDR1, DATA, DONE:
  - HDR0: byte_valid latches count[7:0] → HDR1.
  - HDR1: byte_valid latches count[15:8].
    - count==0 → DONE.
    - otherwise → DATA.
  - DATA: bytes fill the word little-endian (first byte is wdata[7:0]). Words are written to addresses 0,1,2,… in order.
  - DATA, 4th byte accepted: on the following clk edge imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = the assembled word.
  - DATA, after the last word: once word count == count, the cycle after the final imem_we enters DONE.
- Overflow: for word index ≥ DEPTH the word is received but imem_we stays 0, err←1, and words_loaded does not increment. The word still counts toward count.
- words_loaded increments in the same cycle imem_we is high.
- DONE: done=1 and core_rst_n=1 from the DONE-entry edge onward. Further rx traffic is ignored; the RX FSM may run but never writes and never sets err.
- A framing error in a header or data byte does not advance the loader. The sender's image is therefore misaligned; err flags it and host software retries after rst.
- imem_addr holds its last value between writes. imem_wdata holds the last written word.

Test Plan:
- Normal load, CLKS_PER_BIT=4: send 02 00 13 05 00 00 93 05 10 00 →
  - write 0x00000513 @0, then 0x00100593 @1, each imem_we exactly 1 cycle;
  - done=1, core_rst_n=1, words_loaded=2, err=0.
- Empty image: send 00 00 → no imem_we; done=1 one cycle after the 2nd stop bit; words_loaded=0.
- Framing error: header 01 00, then a byte with stop bit forced 0, then 11 22 33 44 →
  - err=1, bad byte dropped;
  - write 0x44332211 @0; done=1.
- Start glitch: rx low for 1 clk (less than half a bit) in IDLE → no byte, err=0, loader state unchanged.
- Overflow, DEPTH=2: header 03 00 plus 12 bytes →
  - writes @0 and @1 only; 3rd word not written;
  - err=1, words_loaded=2, done=1.
- Reset mid-load: rst for 1 cycle after 6 bytes of the first scenario →
  - all outputs at reset values, core_rst_n=0;
  - a full resend reproduces the first scenario's result exactly.
